video_frame_streamer: RTL and testbench

Parametrised successor to the simulation-only screen buffer. It holds a WIDTH x HEIGHT framebuffer written by the CPU bus with per-byte strobes, and supports single-cycle-latency CPU read-back. Instead of dumping to a file, it streams whole frames in raster order over a synthesizable valid/ready pixel port. Streaming runs on a periodic interval when the buffer is dirty, or on an explicit flush request. It sits between the memory-mapped I/O decoder and the display/scanout or testbench sink.

---
 rtl/video_pkg.sv | 20 ++
 rtl/framebuffer_ram.sv | 42 ++++
 rtl/video_frame_streamer.sv | 114 +++++++++++
 tb/tb_video_frame_streamer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the frame streamer: FSM encoding, default
// geometry types and the pixel byte-count helper.
package video_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t PREFETCH = 2'd1;
    localparam state_t STREAM   = 2'd2;

    // Default 256x256 geometry; parametrised instances derive their own widths.
    typedef logic [7:0]  pix_x_t;
    typedef logic [7:0]  pix_y_t;
    typedef logic [15:0] pix_index_t;

    function automatic int pixel_bytes(input int pixel_width);
        return pixel_width / 8;
    endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Framebuffer storage: one byte-enable write port plus CPU and scan read
// ports, both registered and read-first.
module framebuffer_ram
    import video_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [DW-1:0]              wdata,
    input  logic [pixel_bytes(DW)-1:0] wstrb,
    input  logic                       cpu_re,
    input  logic [AW-1:0]              cpu_addr,
    output logic [DW-1:0]              cpu_q,
    input  logic [AW-1:0]              scan_addr,
    output logic [DW-1:0]              scan_q
);

    localparam int NB    = pixel_bytes(DW);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        scan_q <= mem[scan_addr];
    end

    // CPU read-back is a visible output, so it resets; the scan port is gated upstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      cpu_q <= '0;
        else if (cpu_re) cpu_q <= mem[cpu_addr];
    end

endmodule

// File: rtl/video_frame_streamer.sv
// Framebuffer with CPU access that streams whole frames in raster order over
// a valid/ready pixel port, on a dirty-driven interval or on flush request.
module video_frame_streamer
    import video_pkg::*;
#(
    parameter int H_BITS         = 8,
    parameter int V_BITS         = 8,
    parameter int PIXEL_WIDTH    = 24,
    parameter int FLUSH_INTERVAL = 100
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                write,
    input  logic                                read,
    input  logic [H_BITS+V_BITS-1:0]            address,
    input  logic [31:0]                         data,
    input  logic [pixel_bytes(PIXEL_WIDTH)-1:0] strobe,
    output logic [31:0]                         read_data,
    output logic                                read_valid,
    input  logic                                flush_request,
    output logic                                pixel_valid,
    input  logic                                pixel_ready,
    output logic [PIXEL_WIDTH-1:0]              pixel_data,
    output logic [H_BITS-1:0]                   pixel_x,
    output logic [V_BITS-1:0]                   pixel_y,
    output logic                                frame_start,
    output logic                                frame_end,
    output logic                                busy
);

    localparam int AW = H_BITS + V_BITS;
    localparam int CW = $clog2(FLUSH_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FLUSH_INTERVAL);
    localparam logic [AW-1:0] LAST    = '1;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   dirty, pend;
    logic [AW-1:0]          idx, scan_addr;
    logic                   skid_valid;
    logic [PIXEL_WIDTH-1:0] skid_data, scan_q, cpu_q;
    logic                   start, hs;
    logic                   unused_data;

    assign unused_data = ^data;

    assign start = (state == IDLE) && (((cnt >= CNT_MAX) && dirty) || pend);
    assign hs    = (state == STREAM) && pixel_ready;
    // Fetch one ahead on a handshake so the next pixel is presented next cycle.
    assign scan_addr = hs ? idx + AW'(1) : idx;

    framebuffer_ram #(.AW(AW), .DW(PIXEL_WIDTH)) u_ram (
        .clock     (clock),
        .reset     (reset),
        .we        (write),
        .waddr     (address),
        .wdata     (data[PIXEL_WIDTH-1:0]),
        .wstrb     (strobe),
        .cpu_re    (read),
        .cpu_addr  (address),
        .cpu_q     (cpu_q),
        .scan_addr (scan_addr),
        .scan_q    (scan_q)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dirty      <= 1'b0;
            pend       <= 1'b0;
            idx        <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read;
            // A write in the same cycle as a frame start keeps the buffer dirty.
            if (write)      dirty <= 1'b1;
            else if (start) dirty <= 1'b0;
            if (flush_request) pend <= 1'b1;
            else if (start)    pend <= 1'b0;
            if (start)                               cnt <= '0;
            else if (state == IDLE && cnt < CNT_MAX) cnt <= cnt + CW'(1);

            case (state)
                IDLE:     if (start) state <= PREFETCH;
                PREFETCH: state <= STREAM;
                STREAM: begin
                    if (pixel_ready) begin
                        skid_valid <= 1'b0;
                        idx        <= idx + AW'(1);
                        if (idx == LAST) state <= IDLE;
                    end else if (!skid_valid) begin
                        // The RAM keeps reading while stalled; freeze the word on show.
                        skid_valid <= 1'b1;
                        skid_data  <= scan_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign pixel_valid = (state == STREAM);
    assign pixel_data  = pixel_valid ? (skid_valid ? skid_data : scan_q) : '0;
    assign pixel_x     = idx[H_BITS-1:0];
    assign pixel_y     = idx[AW-1:H_BITS];
    assign frame_start = pixel_valid && (idx == '0);
    assign frame_end   = pixel_valid && (idx == LAST);
    assign read_data   = 32'(cpu_q);

endmodule

// File: tb/tb_video_frame_streamer.sv
// Scoreboard bench for video_frame_streamer on a 4x4 framebuffer with a
// short flush interval.
module tb_video_frame_streamer;

    localparam int HB = 2, VB = 2, PW = 24, FI = 10, NPIX = 16;

    logic        clock = 0, reset = 1, write = 0, read = 0;
    logic        flush_request = 0, pixel_ready = 0;
    logic [3:0]  address = '0;
    logic [31:0] data = '0;
    logic [2:0]  strobe = '0;
    logic [31:0] read_data;
    logic        read_valid, pixel_valid, frame_start, frame_end, busy;
    logic [PW-1:0] pixel_data;
    logic [HB-1:0] pixel_x;
    logic [VB-1:0] pixel_y;

    video_frame_streamer #(.H_BITS(HB), .V_BITS(VB), .PIXEL_WIDTH(PW), .FLUSH_INTERVAL(FI)) dut (
        .clock(clock), .reset(reset), .write(write), .read(read), .address(address),
        .data(data), .strobe(strobe), .read_data(read_data), .read_valid(read_valid),
        .flush_request(flush_request), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]    idx;
        logic [PW-1:0] pix;
    } exp_t;

    exp_t        sb[$];
    logic [PW-1:0] model [NPIX];
    int tests = 0, fails = 0;
    int cyc = 0, starts = 0, ends = 0, last_start = 0, last_end = 0;
    bit bp = 0, hold = 0;
    logic [PW-1:0] h_data;
    logic [HB-1:0] h_x;
    logic [VB-1:0] h_y;

    // Pixel-port monitor: stall stability and in-order scoreboard checks
    always @(negedge clock) begin : mon
        exp_t e;
        cyc++;
        if (!reset) begin
            hold = 0;
        end else if (pixel_valid) begin
            if (hold) begin
                tests++;
                if ({pixel_data, pixel_x, pixel_y} !== {h_data, h_x, h_y}) begin
                    fails++;
                    $display("FAIL stall_stable got %h (%0d,%0d) want %h (%0d,%0d)",
                             pixel_data, pixel_x, pixel_y, h_data, h_x, h_y);
                end
            end
            if (pixel_ready) begin
                hold = 0;
                if (frame_start) begin starts++; last_start = cyc; end
                if (frame_end)   begin ends++;   last_end   = cyc; end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pixel got (%0d,%0d) %h want none", pixel_x, pixel_y, pixel_data);
                end else begin
                    e = sb.pop_front();
                    if (pixel_data !== e.pix || pixel_x !== e.idx[1:0] || pixel_y !== e.idx[3:2] ||
                        frame_start !== (e.idx == 4'd0) || frame_end !== (e.idx == 4'd15)) begin
                        fails++;
                        $display("FAIL pixel got %h (%0d,%0d) s%0b e%0b want %h idx %0d",
                                 pixel_data, pixel_x, pixel_y, frame_start, frame_end, e.pix, e.idx);
                    end
                end
            end else begin
                hold = 1; h_data = pixel_data; h_x = pixel_x; h_y = pixel_y;
            end
        end else begin
            hold = 0;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
        if (bp) pixel_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, input logic [2:0] s);
        address = a; data = d; strobe = s; write = 1;
        for (int b = 0; b < 3; b++) if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
        tick();
        write = 0;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.idx = 4'(i); e.pix = model[i]; sb.push_back(e);
        end
    endtask

    task automatic pulse_flush();
        flush_request = 1; tick(); flush_request = 0;
    endtask

    task automatic wait_ends(input int target, input int budget);
        int n = 0;
        while (ends < target && n < budget) begin tick(); n++; end
        tests++;
        if (ends < target) begin fails++; $display("FAIL frame_end_timeout got %0d ends want %0d", ends, target); end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (starts < target && n < budget) begin tick(); n++; end
        tests++;
        if (starts < target) begin fails++; $display("FAIL frame_start_timeout got %0d starts want %0d", starts, target); end
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #2;
        tests += 4;
        if (pixel_valid !== 0 || busy !== 0) begin fails++; $display("FAIL reset_stream got v%0b b%0b want 0 0", pixel_valid, busy); end
        if (read_valid !== 0 || read_data !== 0) begin fails++; $display("FAIL reset_read got %0b %h want 0 0", read_valid, read_data); end
        if (pixel_data !== 0) begin fails++; $display("FAIL reset_pixel_data got %h want 0", pixel_data); end
        if ({frame_start, frame_end, pixel_x, pixel_y} !== 6'd0) begin
            fails++; $display("FAIL reset_flags got %b want 0", {frame_start, frame_end, pixel_x, pixel_y});
        end
        @(posedge clock); @(posedge clock); #1 reset = 1;
    endtask

    // Fill the RAM with the sink stalled, then abort the stalled frame by reset
    task automatic test_fill_and_abort();
        pixel_ready = 0;
        for (int i = 0; i < NPIX; i++) cpu_write(4'(i), 32'(24'(i) * 24'h010101 ^ 24'h5A3C00), 3'b111);
        repeat (4) tick();
        tests++;
        if (busy !== 1 || pixel_valid !== 1 || frame_start !== 1) begin
            fails++; $display("FAIL stalled_frame got b%0b v%0b s%0b want 1 1 1", busy, pixel_valid, frame_start);
        end
        reset = 0; #2;
        tests++;
        if (pixel_valid !== 0 || busy !== 0) begin fails++; $display("FAIL abort_stall got v%0b b%0b want 0 0", pixel_valid, busy); end
        sb.delete();
        tick(); tick(); reset = 1;
    endtask

    task automatic test_rw();
        pixel_ready = 1;
        cpu_write(4'd5, 32'h00ABCDEF, 3'b111);
        read = 1;
        cpu_write(4'd5, 32'h00112233, 3'b010);
        tests++;
        if (read_valid !== 1 || read_data !== 32'h00ABCDEF) begin
            fails++; $display("FAIL read_first got %0b %h want 1 00abcdef", read_valid, read_data);
        end
        cpu_write(4'd5, 32'hFFFFFFFF, 3'b000);
        tests++;
        if (read_valid !== 1 || read_data !== 32'h00AB22EF) begin
            fails++; $display("FAIL byte_strobe got %0b %h want 1 00ab22ef", read_valid, read_data);
        end
        tick();
        tests++;
        if (read_valid !== 1 || read_data !== 32'h00AB22EF) begin
            fails++; $display("FAIL zero_strobe got %0b %h want 1 00ab22ef", read_valid, read_data);
        end
        read = 0;
        tick();
        tests++;
        if (read_valid !== 0) begin fails++; $display("FAIL read_valid_drop got %0b want 0", read_valid); end
        push_frame();
    endtask

    task automatic test_interval_frame();
        int e0;
        wait_ends(1, 60);
        tests++;
        if (last_end - last_start !== 15) begin fails++; $display("FAIL consecutive got %0d want 15", last_end - last_start); end
        e0 = last_end;
        cpu_write(4'd3, 32'h00DEAD00, 3'b000);
        push_frame();
        wait_ends(2, 60);
        tests += 2;
        if (last_start - e0 !== 13) begin fails++; $display("FAIL interval_gap got %0d want 13", last_start - e0); end
        if (last_end - last_start !== 15) begin fails++; $display("FAIL consecutive2 got %0d want 15", last_end - last_start); end
        repeat (40) tick();
        tests++;
        if (starts !== 2 || busy !== 0) begin fails++; $display("FAIL no_extra_frame got %0d starts b%0b want 2 0", starts, busy); end
    endtask

    task automatic test_backpressure();
        bp = 1;
        pulse_flush();
        push_frame();
        wait_ends(ends + 1, 400);
        bp = 0; pixel_ready = 1;
        tests++;
        if (sb.size() !== 0) begin fails++; $display("FAIL bp_leftover got %0d want 0", sb.size()); end
    endtask

    task automatic test_write_during_stream();
        int e0, e1;
        e0 = ends;
        pulse_flush();
        push_frame();
        wait_starts(starts + 1, 20);
        cpu_write(4'd15, 32'h00F1F2F3, 3'b111);
        foreach (sb[i]) if (sb[i].idx == 4'd15) sb[i].pix = model[15];
        cpu_write(4'd0, 32'h00C0FFEE, 3'b111);
        push_frame();
        wait_ends(e0 + 1, 60);
        e1 = last_end;
        wait_ends(e0 + 2, 60);
        tests += 2;
        if (last_start - e1 !== 13) begin fails++; $display("FAIL auto_refollow got %0d want 13", last_start - e1); end
        if (sb.size() !== 0) begin fails++; $display("FAIL stream_write_leftover got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_midframe();
        int s0, e0, e1;
        bp = 1;
        pulse_flush();
        push_frame();
        wait_starts(starts + 1, 100);
        repeat (3) tick();
        tests++;
        if (busy !== 1) begin fails++; $display("FAIL midframe_busy got %0b want 1", busy); end
        reset = 0; #2;
        tests++;
        if (pixel_valid !== 0 || busy !== 0) begin fails++; $display("FAIL abort_mid got v%0b b%0b want 0 0", pixel_valid, busy); end
        sb.delete();
        bp = 0; pixel_ready = 1;
        tick(); tick(); reset = 1;
        s0 = starts; e0 = ends;
        repeat (30) tick();
        tests++;
        if (starts !== s0 || busy !== 0) begin fails++; $display("FAIL idle_after_reset got %0d starts b%0b want %0d 0", starts, busy, s0); end
        pulse_flush();
        push_frame();
        wait_starts(s0 + 1, 20);
        pulse_flush();
        push_frame();
        wait_ends(e0 + 1, 60);
        e1 = last_end;
        wait_ends(e0 + 2, 60);
        tests += 2;
        if (last_start - e1 !== 3) begin fails++; $display("FAIL latched_flush_gap got %0d want 3", last_start - e1); end
        if (sb.size() !== 0) begin fails++; $display("FAIL preserved_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fill_and_abort();
        test_rw();
        test_interval_frame();
        test_backpressure();
        test_write_during_stream();
        test_reset_midframe();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
